// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: op-code encoding and depth helper.
package fifo_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_NO_OP    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_READ     = 3'd3,
    ST_WR_ERROR = 3'd4,
    ST_RD_ERROR = 3'd5,
    ST_WR_RD    = 3'd6
  } state_e;

  localparam logic [2:0] ST_ILLEGAL = 3'd7;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_reg_file.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, registered read port that holds when idle.
module fifo_reg_file
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] dout_q;

  // Storage is deliberately not reset; only locations already written are ever read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= din;
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (re) begin
      dout_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: op decision, head/tail/count, registered flags and ack/err pulses.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [2:0]            state
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(fifo_depth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  rd_err_q, rd_err_d;
  logic                  mem_we;
  logic                  mem_re;

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    wr_ack_d = 1'b0;
    wr_err_d = 1'b0;
    rd_ack_d = 1'b0;
    rd_err_d = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;

    // An unencodable state register value drops the request and returns to INIT.
    if (3'(state_q) == ST_ILLEGAL) begin
      state_d = ST_INIT;
    end else if (clr) begin
      state_d = ST_INIT;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      case ({wr_en, rd_en})
        2'b00: state_d = ST_NO_OP;
        2'b10: begin
          if (count_q != DEPTH_C) begin
            state_d  = ST_WRITE;
            mem_we   = 1'b1;
            tail_d   = tail_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
            wr_ack_d = 1'b1;
          end else begin
            state_d  = ST_WR_ERROR;
            wr_err_d = 1'b1;
          end
        end
        2'b01: begin
          if (count_q != '0) begin
            state_d  = ST_READ;
            mem_re   = 1'b1;
            head_d   = head_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
            rd_ack_d = 1'b1;
          end else begin
            state_d  = ST_RD_ERROR;
            rd_err_d = 1'b1;
          end
        end
        default: begin
          // Empty FIFO: no read-through of din, the read half is rejected.
          if (count_q == '0) begin
            state_d  = ST_WRITE;
            mem_we   = 1'b1;
            tail_d   = tail_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
            wr_ack_d = 1'b1;
            rd_err_d = 1'b1;
          end else begin
            // When full, head==tail: the registered read captures the pre-write word.
            state_d  = ST_WR_RD;
            mem_we   = 1'b1;
            mem_re   = 1'b1;
            head_d   = head_q + PTR_ONE;
            tail_d   = tail_q + PTR_ONE;
            wr_ack_d = 1'b1;
            rd_ack_d = 1'b1;
          end
        end
      endcase
    end

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_INIT;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

  fifo_reg_file #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_reg_file (
    .clk  (clk),
    .reset(reset),
    .we   (mem_we),
    .waddr(tail_q),
    .din  (din),
    .re   (mem_re),
    .raddr(head_q),
    .dout (dout)
  );

  assign data_count   = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign wr_ack       = wr_ack_q;
  assign wr_err       = wr_err_q;
  assign rd_ack       = rd_ack_q;
  assign rd_err       = rd_err_q;
  assign state        = 3'(state_q);

endmodule

// File: tb/tb_fifo_param.sv
// Directed plus randomized bench for fifo_param against a queue-based reference model.
module tb_fifo_param;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic [AW:0]   data_count;
  logic          full, empty, almost_full, almost_empty;
  logic          wr_ack, wr_err, rd_ack, rd_err;
  logic [2:0]    state;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic [2:0]    m_state;
  logic          m_wr_ack, m_wr_err, m_rd_ack, m_rd_err;

  fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .data_count(data_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".data_count"}, DW'(data_count), DW'(n));
    chk({tag, ".full"}, DW'(full), DW'(n == DEPTH));
    chk({tag, ".empty"}, DW'(empty), DW'(n == 0));
    chk({tag, ".almost_full"}, DW'(almost_full), DW'(n >= DEPTH - 1));
    chk({tag, ".almost_empty"}, DW'(almost_empty), DW'(n <= 1));
    chk({tag, ".dout"}, dout, m_dout);
    chk({tag, ".state"}, DW'(state), DW'(m_state));
    chk({tag, ".wr_ack"}, DW'(wr_ack), DW'(m_wr_ack));
    chk({tag, ".wr_err"}, DW'(wr_err), DW'(m_wr_err));
    chk({tag, ".rd_ack"}, DW'(rd_ack), DW'(m_rd_ack));
    chk({tag, ".rd_err"}, DW'(rd_err), DW'(m_rd_err));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_state = 3'd0;
    {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err} = 4'b0;
  endtask

  // One request per cycle: model the FIFO rules directly on a queue.
  task automatic model_step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
    {m_wr_ack, m_wr_err, m_rd_ack, m_rd_err} = 4'b0;
    if (c) begin
      q.delete();
      m_state = 3'd0;
    end else if (!w && !r) begin
      m_state = 3'd1;
    end else if (w && !r) begin
      if (q.size() < DEPTH) begin q.push_back(d); m_wr_ack = 1'b1; m_state = 3'd2; end
      else begin m_wr_err = 1'b1; m_state = 3'd4; end
    end else if (r && !w) begin
      if (q.size() > 0) begin m_dout = q.pop_front(); m_rd_ack = 1'b1; m_state = 3'd3; end
      else begin m_rd_err = 1'b1; m_state = 3'd5; end
    end else begin
      if (q.size() == 0) begin
        q.push_back(d); m_wr_ack = 1'b1; m_rd_err = 1'b1; m_state = 3'd2;
      end else begin
        m_dout = q.pop_front(); q.push_back(d);
        m_wr_ack = 1'b1; m_rd_ack = 1'b1; m_state = 3'd6;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic c, input logic w, input logic r,
                       input logic [DW-1:0] d);
    @(negedge clk);
    clr = c; wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    model_step(c, w, r, d);
    #1;
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 3; i++) do_op("idle", 1'b0, 1'b0, 1'b0, '0);

    for (int i = 1; i <= 8; i++) do_op($sformatf("fill%0d", i), 1'b0, 1'b1, 1'b0, DW'(32'h11 * i));
    do_op("wr_overflow", 1'b0, 1'b1, 1'b0, 32'h99);

    for (int i = 1; i <= 8; i++) begin
      do_op($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b1, '0);
      chk($sformatf("drain%0d.value", i), dout, DW'(32'h11 * i));
    end
    do_op("rd_underflow", 1'b0, 1'b0, 1'b1, '0);
    chk("rd_underflow.hold", dout, 32'h88);

    for (int i = 0; i < 6; i++) do_op("wrap_w6", 1'b0, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 6; i++) do_op("wrap_r6", 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) do_op("wrap_w5", 1'b0, 1'b1, 1'b0, $urandom);
    chk("wrap.count5", DW'(data_count), 32'd5);
    for (int i = 0; i < 5; i++) do_op("wrap_r5", 1'b0, 1'b0, 1'b1, '0);

    do_op("both_empty", 1'b0, 1'b1, 1'b1, 32'hCAFE_0001);
    for (int i = 0; i < 7; i++) do_op("refill", 1'b0, 1'b1, 1'b0, $urandom);
    do_op("both_full", 1'b0, 1'b1, 1'b1, 32'hBEEF_0002);
    chk("both_full.count", DW'(data_count), 32'd8);

    for (int i = 0; i < 4; i++) do_op("pre_clr", 1'b0, 1'b0, 1'b1, '0);
    do_op("clr", 1'b1, 1'b1, 1'b1, 32'h1234);
    chk("clr.state_init", DW'(state), 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic c, w, r;
      c = ($urandom_range(0, 31) == 0);
      w = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 1) == 1;
      do_op("rand", c, w, r, $urandom);
    end

    // Async reset arriving between edges while a write is being presented.
    @(negedge clk);
    wr_en = 1'b1; din = 32'h5555_AAAA;
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("async_reset");
    @(negedge clk);
    wr_en = 1'b0;
    reset = 1'b0;
    do_op("post_reset_idle", 1'b0, 1'b0, 1'b0, '0);
    do_op("post_reset_write", 1'b0, 1'b1, 1'b0, 32'h7777);
    do_op("post_reset_read", 1'b0, 1'b0, 1'b1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO: control state machine, head/tail/count logic and storage in one block.
- Successor to the fixed 8-entry FIFO controller. Adds:
  - generic width and depth;
  - simultaneous read+write;
  - almost-full/almost-empty thresholds;
  - synchronous clear;
  - registered ack/error pulses.
- Sits between a producer and a consumer on the same clock domain.

Parameters:
DATA_WIDTH, 32, bits per entry
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries
AF_LEVEL, DEPTH-1, almost_full asserted when data_count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserted when data_count <= AE_LEVEL

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
clr  input  1  synchronous clear; priority over wr_en/rd_en
wr_en  input  1  write request
din  input  DATA_WIDTH  write data
rd_en  input  1  read request
dout  output  DATA_WIDTH  read data, registered
data_count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH
full, empty  output  1  occupancy flags
almost_full, almost_empty  output  1  threshold flags
wr_ack, wr_err  output  1  one-cycle pulses per write request
rd_ack, rd_err  output  1  one-cycle pulses per read request
state  output  3  current op code, for debug

Behaviour:
- Reset (async, while reset=1):
  - head=tail=0, data_count=0, state=INIT;
  - dout=0, empty=1, full=0, almost_empty=1, almost_full=0;
  - all ack/err outputs 0.
- Registers: all state and outputs update on the rising clk edge. The decision for each cycle uses that cycle's wr_en, rd_en and the current data_count.
- State encoding: INIT=0, NO_OP=1, WRITE=2, READ=3, WR_ERROR=4, RD_ERROR=5, WR_RD=6. Register `state` holds the op decided at the last edge.
- Decision table, first match wins:
  - clr=1: INIT; pointers and count cleared; acks and errs 0; dout holds.
  - wr_en=0, rd_en=0: NO_OP; nothing changes.
  - wr_en=1, rd_en=0, count<DEPTH: WRITE; mem[tail]<=din; tail+1; count+1; wr_ack=1.
  - wr_en=1, rd_en=0, count==DEPTH: WR_ERROR; wr_err=1; no pointer or count change; memory untouched.
  - rd_en=1, wr_en=0, count>0: READ; dout<=mem[head]; head+1; count-1; rd_ack=1.
  - rd_en=1, wr_en=0, count==0: RD_ERROR; rd_err=1; dout holds; no change.
  - both=1, count==0: state=WRITE; write as above; rd_err=1. There is no read-through of din.
  - both=1, 0<count<=DEPTH: WR_RD; read mem[head] into dout and write din to mem[tail]; both pointers +1; count unchanged; wr_ack=rd_ack=1. When full, the write takes the slot freed by the read, and dout receives the pre-write content.
- Latency:
  - ack/err pulses appear in the cycle after the request edge;
  - dout is valid in the same cycle that rd_ack is high;
  - flags reflect the post-update data_count.
- Arithmetic:
  - pointers wrap modulo DEPTH naturally (ADDR_WIDTH bits);
  - count is ADDR_WIDTH+1 bits and never exceeds DEPTH or goes below 0.
- Flags:
  - full = (count==DEPTH); empty = (count==0);
  - almost flags compare count against the AF_LEVEL/AE_LEVEL parameters;
  - all flags are registered with count.
- Reset mid-operation: immediate return to reset values; in-flight requests are dropped.
- Memory contents are not reset.
- No X is ever driven on outputs; any illegal state register value recovers to INIT on the next edge.

Decomposition:
- Package fifo_pkg: state encoding constants (INIT..WR_RD, 3 bits) and a DEPTH function of ADDR_WIDTH.
- Sub-module fifo_reg_file:
  - DEPTH x DATA_WIDTH array;
  - synchronous write port (we, waddr, din);
  - registered read port (re, raddr, dout);
  - dout holds when re=0.
- fifo_param holds the control FSM, pointers, count and flags, and instantiates fifo_reg_file.

Test Plan (DATA_WIDTH=32, ADDR_WIDTH=3):
- Reset then idle 3 cycles -> empty=1, full=0, data_count=0, state=NO_OP, dout=0.
- Write 0x11..0x88 (8 writes) -> eight wr_ack pulses, full=1, almost_full=1 after the 7th, data_count=8. Then a 9th write 0x99 -> wr_err=1, state=WR_ERROR, count stays 8.
- From full, read 8 times -> dout 0x11..0x88 in order with rd_ack each. Then a further read -> rd_err=1, dout stays 0x88, empty=1.
- Wrap: write 6, read 6, write 5 -> tail wraps past 7, count=5. Reading back returns the 5 written values in order.
- Simultaneous: both requests at count=0 -> WRITE with rd_err=1, count=1. Both requests at count=8 -> WR_RD, count stays 8, dout=oldest entry, new data at the tail.
- Mid-stream checks:
  - clr at count=4 -> next cycle count=0, empty=1, state=INIT;
  - async reset during a write -> outputs drop to reset values before the next edge.
